// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC register, next-PC select, IF/ID register
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 10,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch,
  input  logic               jump,
  input  logic               jr,
  input  logic [31:0]        rs_value,
  input  logic [31:0]        imem_rdata,
  input  logic               imem_ready,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        pc,
  output logic [31:0]        id_inst,
  output logic [31:0]        id_pc4,
  output logic               id_valid,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        squash_cnt
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] squash_cnt_q, squash_cnt_d;

  logic [31:0] pc4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] target;
  logic        redirect;

  assign pc4       = pc_q + 32'd4;
  assign br_target = id_pc4_q + {{14{id_inst_q[15]}}, id_inst_q[15:0], 2'b00};
  assign j_target  = {id_pc4_q[31:28], id_inst_q[25:0], 2'b00};

  always_comb begin
    target = br_target;
    if (jr) begin
      target = rs_value;
    end else if (jump) begin
      target = j_target;
    end
  end

  // A redirect request is only meaningful when ID holds a real instruction.
  assign redirect = branch && id_valid_q && !stall;

  always_comb begin
    pc_d         = pc_q;
    id_inst_d    = id_inst_q;
    id_pc4_d     = id_pc4_q;
    id_valid_d   = id_valid_q;
    fetch_cnt_d  = fetch_cnt_q;
    squash_cnt_d = squash_cnt_q;
    if (stall) begin
      pc_d = pc_q;
    end else if (redirect) begin
      pc_d       = target;
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
      if (imem_ready) begin
        squash_cnt_d = squash_cnt_q + 32'd1;
      end
    end else if (!imem_ready) begin
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
    end else begin
      pc_d        = pc4;
      id_inst_d   = imem_rdata;
      id_pc4_d    = pc4;
      id_valid_d  = 1'b1;
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      id_inst_q    <= NOP_INST;
      id_pc4_q     <= 32'd0;
      id_valid_q   <= 1'b0;
      fetch_cnt_q  <= 32'd0;
      squash_cnt_q <= 32'd0;
    end else begin
      pc_q         <= pc_d;
      id_inst_q    <= id_inst_d;
      id_pc4_q     <= id_pc4_d;
      id_valid_q   <= id_valid_d;
      fetch_cnt_q  <= fetch_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  // Bits [1:0] are dropped so a misaligned JR target still indexes a word.
  assign imem_addr  = pc_q[IMEM_AW+1:2];
  assign pc         = pc_q;
  assign id_inst    = id_inst_q;
  assign id_pc4     = id_pc4_q;
  assign id_valid   = id_valid_q;
  assign fetch_cnt  = fetch_cnt_q;
  assign squash_cnt = squash_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage
module tb_if_stage;

  localparam int          AW  = 10;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst, stall, branch, jump, jr, imem_ready;
  logic [31:0]   rs_value, imem_rdata;
  logic [AW-1:0] imem_addr;
  logic [31:0]   pc, id_inst, id_pc4, fetch_cnt, squash_cnt;
  logic          id_valid;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        pc4_chk;
    logic        valid;
    logic [31:0] fc;
    logic [31:0] sc;
  } exp_t;

  exp_t sb[$];

  logic [31:0] m_pc, m_inst, m_id_pc4, m_fc, m_sc;
  logic        m_valid;
  logic        m_pc4_known;

  if_stage #(.RESET_PC(32'h0), .IMEM_AW(AW), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch(branch), .jump(jump), .jr(jr),
    .rs_value(rs_value), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .imem_addr(imem_addr), .pc(pc), .id_inst(id_inst), .id_pc4(id_pc4),
    .id_valid(id_valid), .fetch_cnt(fetch_cnt), .squash_cnt(squash_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic b, input logic j,
                      input logic jr_i, input logic [31:0] rs, input logic [31:0] rd,
                      input logic rdy);
    exp_t e, o;
    logic [31:0] m_pc4, tgt;
    rst = r; stall = s; branch = b; jump = j; jr = jr_i;
    rs_value = rs; imem_rdata = rd; imem_ready = rdy;
    m_pc4 = m_pc + 32'd4;
    if (jr_i)   tgt = rs;
    else if (j) tgt = {m_id_pc4[31:28], m_inst[25:0], 2'b00};
    else        tgt = m_id_pc4 + {{14{m_inst[15]}}, m_inst[15:0], 2'b00};
    if (r) begin
      m_pc = 32'h0; m_inst = NOP; m_id_pc4 = 32'h0; m_valid = 1'b0;
      m_fc = 32'h0; m_sc = 32'h0; m_pc4_known = 1'b1;
    end else if (s) begin
      m_pc = m_pc;
    end else if (b && m_valid) begin
      m_pc = tgt; m_inst = NOP; m_valid = 1'b0; m_pc4_known = 1'b0;
      if (rdy) m_sc = m_sc + 32'd1;
    end else if (!rdy) begin
      m_inst = NOP; m_valid = 1'b0; m_pc4_known = 1'b0;
    end else begin
      m_inst = rd; m_id_pc4 = m_pc4; m_pc = m_pc4; m_valid = 1'b1;
      m_fc = m_fc + 32'd1; m_pc4_known = 1'b1;
    end
    e.pc = m_pc; e.addr = {22'd0, m_pc[AW+1:2]}; e.inst = m_inst; e.pc4 = m_id_pc4;
    e.pc4_chk = m_pc4_known; e.valid = m_valid; e.fc = m_fc; e.sc = m_sc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = sb.pop_front();
    chk("pc", pc, o.pc);
    chk("imem_addr", {22'd0, imem_addr}, o.addr);
    chk("id_inst", id_inst, o.inst);
    if (o.pc4_chk) chk("id_pc4", id_pc4, o.pc4);
    chk("id_valid", {31'd0, id_valid}, {31'd0, o.valid});
    chk("fetch_cnt", fetch_cnt, o.fc);
    chk("squash_cnt", squash_cnt, o.sc);
  endtask

  initial begin
    m_pc = 0; m_inst = NOP; m_id_pc4 = 0; m_valid = 0; m_fc = 0; m_sc = 0; m_pc4_known = 1;
    rst = 1; stall = 0; branch = 0; jump = 0; jr = 0;
    rs_value = 0; imem_rdata = 0; imem_ready = 0;
    @(negedge clk);

    step(1, 0, 0, 0, 0, 0, 32'h0, 0);
    chk("reset_pc", pc, 32'h0);
    chk("reset_valid", {31'd0, id_valid}, 32'd0);

    step(0, 0, 0, 0, 0, 0, 32'h1111_1111, 1);
    chk("fetch_a_pc", pc, 32'h4);
    step(0, 0, 0, 0, 0, 0, 32'h2222_2222, 1);
    chk("fetch_b_inst", id_inst, 32'h2222_2222);
    chk("fetch_b_pc4", id_pc4, 32'h8);

    step(0, 1, 0, 0, 0, 0, 32'h3333_3333, 1);
    step(0, 1, 0, 0, 0, 0, 32'h3333_3333, 1);
    chk("stall_inst", id_inst, 32'h2222_2222);
    chk("stall_pc", pc, 32'h8);
    chk("stall_fetch", fetch_cnt, 32'd2);

    step(0, 0, 0, 0, 0, 0, 32'h3333_3333, 1);
    chk("fetch_c_pc", pc, 32'hC);
    chk("fetch_c_cnt", fetch_cnt, 32'd3);

    step(0, 0, 0, 0, 0, 0, 32'h1000_FFFE, 1);
    chk("beq_pc4", id_pc4, 32'h10);
    step(0, 0, 1, 0, 0, 0, 32'hDEAD_BEEF, 1);
    chk("beq_target", pc, 32'h8);
    chk("beq_squash", squash_cnt, 32'd1);
    chk("beq_addr", {22'd0, imem_addr}, 32'd2);

    step(0, 0, 0, 0, 0, 0, 32'h0800_0040, 1);
    chk("after_beq_pc4", id_pc4, 32'hC);
    step(0, 0, 1, 1, 0, 0, 32'h0, 0);
    chk("j_target", pc, 32'h100);
    chk("j_notready_squash", squash_cnt, 32'd1);

    step(0, 0, 0, 0, 0, 0, 32'h0000_0008, 1);
    step(0, 0, 1, 0, 1, 32'h200, 32'hAAAA_0000, 1);
    chk("jr_target", pc, 32'h200);

    step(0, 0, 0, 0, 0, 0, 32'h0800_0123, 1);
    step(0, 0, 1, 1, 1, 32'h300, 32'hAAAA_0001, 1);
    chk("jr_over_j", pc, 32'h300);

    step(0, 0, 0, 0, 0, 0, 32'h0800_0080, 1);
    step(0, 1, 1, 1, 0, 0, 32'hAAAA_0002, 1);
    chk("stall_branch_pc", pc, 32'h304);
    chk("stall_branch_valid", {31'd0, id_valid}, 32'd1);
    step(0, 0, 1, 1, 0, 0, 32'hAAAA_0003, 1);
    chk("redir_once_pc", pc, 32'h200);
    step(0, 0, 1, 1, 0, 0, 32'h4444_4444, 1);
    chk("bubble_ignores_branch", pc, 32'h204);
    chk("squash_total", squash_cnt, 32'd4);

    step(0, 0, 0, 0, 0, 0, 32'h5555_5555, 0);
    chk("notready_pc", pc, 32'h204);
    chk("notready_fetch", fetch_cnt, 32'd9);

    step(0, 0, 0, 0, 0, 0, 32'h6666_6666, 1);
    step(0, 0, 1, 0, 1, 32'h203, 32'h0, 1);
    chk("misaligned_pc", pc, 32'h203);
    chk("misaligned_addr", {22'd0, imem_addr}, 32'h80);
    step(0, 0, 0, 0, 0, 0, 32'h7777_7777, 1);
    chk("misaligned_pc4", id_pc4, 32'h207);

    step(1, 1, 1, 1, 0, 0, 32'h8888_8888, 1);
    chk("rst_stall_pc", pc, 32'h0);
    chk("rst_stall_fetch", fetch_cnt, 32'd0);
    chk("rst_stall_squash", squash_cnt, 32'd0);
    chk("rst_stall_inst", id_inst, NOP);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
